// File: rtl/bcd_conv_pkg.sv
// Shared types and helpers for the streaming binary-to-BCD converter.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ceil(width * log10(2)); the product is never an integer for width > 0
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a digit of 5 or more gets 3 added (4-bit wrap).
module bcd_add3_digit (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bcd_stream_converter.sv
// Parametrised double-dabble binary-to-BCD converter with valid/ready on both sides.
// Optional macro BCD_SIGNED_EN: two's complement input, magnitude converted, sign on o_neg.
module bcd_stream_converter
  import bcd_conv_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [IN_WIDTH-1:0]          i_in_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [4*DIGITS-1:0]          o_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  o_ndigits,
`ifdef BCD_SIGNED_EN
  output logic                         o_neg,
`endif
  output logic                         o_overflow
);

  localparam int BW  = 4 * DIGITS;
  localparam int NDW = $clog2(DIGITS + 1);
  localparam int CW  = $clog2(IN_WIDTH);

  if (DIGITS < min_digits(IN_WIDTH)) begin : g_digitsWarn
    $warning("bcd_stream_converter: DIGITS=%0d is below %0d for IN_WIDTH=%0d, overflow is reachable",
             DIGITS, min_digits(IN_WIDTH), IN_WIDTH);
  end

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_bin;
  logic [BW-1:0]       r_digits;
  logic                r_ovf;
  logic [CW-1:0]       r_cnt;

  logic [BW-1:0]       w_adj;
  logic [BW-1:0]       w_digitsNext;
  logic [IN_WIDTH-1:0] w_binNext;
  logic [IN_WIDTH-1:0] w_load;
  logic                w_ovfNext;
  logic [NDW-1:0]      w_ndNext;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_digit (r_digits[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // One combined correct-and-shift step of {digits, bin} per clock
  assign w_digitsNext = {w_adj[BW-2:0], r_bin[IN_WIDTH-1]};
  assign w_binNext    = {r_bin[IN_WIDTH-2:0], 1'b0};
  assign w_ovfNext    = r_ovf | w_adj[BW-1];

`ifdef BCD_SIGNED_EN
  assign w_load = i_in_data[IN_WIDTH-1] ? -i_in_data : i_in_data;
`else
  assign w_load = i_in_data;
`endif

  always_comb begin
    w_ndNext = NDW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (w_digitsNext[4*i +: 4] != 4'd0) w_ndNext = NDW'(i + 1);
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_digits   <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      o_bcd      <= '0;
      o_ndigits  <= NDW'(1);
      o_overflow <= 1'b0;
`ifdef BCD_SIGNED_EN
      o_neg      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_bin    <= w_load;
            r_digits <= '0;
            r_ovf    <= 1'b0;
            r_cnt    <= CW'(IN_WIDTH - 1);
`ifdef BCD_SIGNED_EN
            o_neg    <= i_in_data[IN_WIDTH-1];
`endif
            r_state  <= S_CONV;
          end
        end
        S_CONV: begin
          r_bin    <= w_binNext;
          r_digits <= w_digitsNext;
          r_ovf    <= w_ovfNext;
          if (r_cnt == '0) begin
            o_bcd      <= w_digitsNext;
            o_ndigits  <= w_ndNext;
            o_overflow <= w_ovfNext;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (i_out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcd_stream_converter.md
# bcd_stream_converter

Parametrised double-dabble binary-to-BCD converter with valid/ready handshakes on both sides. It replaces the fixed 32-bit trigger/idle converter in display and readout paths. Width and digit count are generic. It performs a combined add-3/shift per clock, which halves latency. It reports the number of significant digits and flags overflow when the digit count is too small for the value.

## Interface
- IN_WIDTH, default 32: width of the binary input, range 4..64.
- DIGITS, default 10: number of BCD output digits. The output bus is 4*DIGITS bits wide.
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  the binary word on in_data is valid.
- in_ready  output  1  the converter can accept a word. Equal to 1 only in S_IDLE.
- in_data  input  IN_WIDTH  binary operand.
- out_valid  output  1  the result is valid. Held until accepted.
- out_ready  input  1  the consumer accepts the result.
- bcd  output  4*DIGITS  packed BCD. Digit 0 is at bits [3:0].
- ndigits  output  $clog2(DIGITS+1)  count of significant digits, 1..DIGITS. A value of 0 reports 1.
- overflow  output  1  a nonzero bit was shifted out of the top digit. bcd then holds the value modulo 10^DIGITS.
- neg  output  1  only present with BCD_SIGNED_EN. Sign of the operand.

## Operation
- FSM states: S_IDLE, S_CONV, S_DONE.
- S_IDLE:
  - in_ready=1.
  - When in_valid and in_ready are both high: load bin_reg with in_data, clear the digit register, clear overflow, load cnt with IN_WIDTH-1, go to S_CONV.
- S_CONV, once per cycle:
  - For each digit ≥5, add 3 (4-bit wrap).
  - Shift {digits, bin_reg} left by 1.
  - The bit leaving the top digit ORs into overflow.
  - When cnt==0, register bcd, ndigits and overflow from the post-shift value and go to S_DONE. Otherwise decrement cnt.
- S_DONE:
  - out_valid=1; bcd, ndigits and overflow are held stable.
  - When out_valid and out_ready are both high, go to S_IDLE.
- ndigits = index of the most significant nonzero digit + 1, with a minimum of 1.
- Boundary behaviour:
  - in_valid while not in S_IDLE: ignored; the producer must hold the word.
  - out_ready asserted before out_valid: no effect.
  - An illegal state encoding goes to S_IDLE.
  - reset asserted mid-conversion: abandons the conversion. out_valid stays 0 and no partial result is emitted.

## Timing
- Reset values: state=S_IDLE, in_ready=1, out_valid=0, bcd=0, ndigits=1, overflow=0, neg=0.
- Latency: if the input handshake occurs at edge E, the FSM spends exactly IN_WIDTH cycles in S_CONV. out_valid rises after edge E+IN_WIDTH.
- Throughput: one word per IN_WIDTH+2 cycles with out_ready tied high. The added cycles are the S_DONE handshake cycle and the S_IDLE accept cycle.
- bcd changes only on the edge that enters S_DONE. Between results it keeps the last value.
- All outputs are registered except in_ready and out_valid, which are decoded from state.

## Configuration
- BCD_SIGNED_EN defined:
  - in_data is two's complement. The magnitude is loaded into bin_reg; -2^(IN_WIDTH-1) yields the magnitude 2^(IN_WIDTH-1).
  - neg is registered at accept and held through S_DONE.
  - Zero gives neg=0.
- Not defined: in_data is unsigned, the neg port is absent, and there is no negation logic.

## Structure
- Package bcd_conv_pkg contains:
  - the state enum state_t (S_IDLE, S_CONV, S_DONE);
  - the constant function min_digits(width), which returns ceil(width*log10 2) and is used by elaboration checks and benches.
- Elaboration warning when DIGITS < min_digits(IN_WIDTH), because overflow is then reachable.
- Sub-module bcd_add3_digit: a combinational 4-bit "≥5 then +3" cell, instantiated DIGITS times in a generate loop.

## Test plan
- Default parameters, in_data=0 → bcd=0, ndigits=1, overflow=0. out_valid rises 32 cycles after the accept edge.
- in_data=32'hFFFF_FFFF → bcd=40'h42_9496_7295, ndigits=10, overflow=0.
- in_data=12345 with out_ready low for 5 cycles → bcd=40'h12345, ndigits=5. bcd is stable and in_ready=0 throughout; the FSM is back in S_IDLE one cycle after out_ready rises.
- IN_WIDTH=16, DIGITS=4, in_data=12345 → bcd=16'h2345, overflow=1, ndigits=4.
- Reset asserted 10 cycles into converting 999 → out_valid never rises and in_ready=1 after the reset edge. A following conversion of 7 gives bcd=7.
- BCD_SIGNED_EN: in_data=-1 → neg=1, bcd=1. in_data=32'h8000_0000 → neg=1, bcd=40'h21_4748_3648.
